// File: rtl/tdc_data_tx.sv
// Serial frame transmitter for TDC data words: a small input FIFO feeds a start/data/stop serializer paced by BIT_CE.
// Define TDC_TX_PARITY_EN to append an even-parity bit after the data bits.
module tdc_data_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          BUS_CLK,
    input  logic                          BUS_RST,
    input  logic                          BIT_CE,
    input  logic [DATA_WIDTH-1:0]         DATA_IN,
    input  logic                          DATA_VALID,
    output logic                          DATA_READY,
    output logic                          DATA_OUT,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int BIT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef TDC_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } tx_state_t;

    tx_state_t              state;
    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic [BIT_W-1:0]       bit_cnt;
    logic                   push;
    logic                   pop;
`ifdef TDC_TX_PARITY_EN
    logic                   parity_bit;
`endif

    // Ready and pop both look only at the registered occupancy, so a same-cycle pop never frees a full slot early.
    assign DATA_READY = (count != FULL_COUNT);
    assign push       = DATA_VALID && DATA_READY;
    assign pop        = BIT_CE && ((state == IDLE) || (state == STOP)) && (count != '0);
    assign BUSY       = (state != IDLE) || (count != '0);
    assign FIFO_COUNT = count;

    always_ff @(posedge BUS_CLK) begin
        if (push) begin
            mem[wr_ptr] <= DATA_IN;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The shift register is pre-shifted as each bit is launched, so its MSB is always the next data bit to send.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state     <= IDLE;
            DATA_OUT  <= 1'b0;
            shift_reg <= '0;
            bit_cnt   <= '0;
`ifdef TDC_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else if (BIT_CE) begin
            case (state)
                IDLE, STOP: begin
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
`ifdef TDC_TX_PARITY_EN
                        parity_bit <= ^mem[rd_ptr];
`endif
                        DATA_OUT  <= 1'b1;
                        state     <= START;
                    end else begin
                        DATA_OUT  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                START: begin
                    DATA_OUT  <= shift_reg[DATA_WIDTH-1];
                    shift_reg <= shift_reg << 1;
                    bit_cnt   <= LAST_BIT;
                    state     <= DATA;
                end
                DATA: begin
                    if (bit_cnt == '0) begin
`ifdef TDC_TX_PARITY_EN
                        DATA_OUT <= parity_bit;
                        state    <= PARITY;
`else
                        DATA_OUT <= 1'b0;
                        state    <= STOP;
`endif
                    end else begin
                        DATA_OUT  <= shift_reg[DATA_WIDTH-1];
                        shift_reg <= shift_reg << 1;
                        bit_cnt   <= bit_cnt - BIT_W'(1);
                    end
                end
`ifdef TDC_TX_PARITY_EN
                PARITY: begin
                    DATA_OUT <= 1'b0;
                    state    <= STOP;
                end
`endif
                default: begin
                    DATA_OUT <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tdc_data_tx.md
TDC_DATA_TX -- requirements
Module: tdc_data_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width in bits of each transmitted data word.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: number of input buffer entries; power of two, minimum 2.
REQ-003 SHALL have port BUS_CLK  input  1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port BUS_RST  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port BIT_CE  input  1: bit-rate strobe; one BUS_CLK cycle wide per serial bit period.
REQ-006 SHALL have port DATA_IN  input  DATA_WIDTH: word to transmit.
REQ-007 SHALL have port DATA_VALID  input  1: DATA_IN is valid.
REQ-008 SHALL have port DATA_READY  output  1: buffer can accept a word.
REQ-009 SHALL have port DATA_OUT  output  1: registered serial line to the receiver.
REQ-010 SHALL have port BUSY  output  1: a frame is in progress or the buffer is non-empty.
REQ-011 SHALL have port FIFO_COUNT  output  clog2(FIFO_DEPTH)+1: current buffer occupancy.

Function
REQ-012 SHALL push DATA_IN into the FIFO on a cycle with DATA_VALID=1 and DATA_READY=1.
REQ-013 SHALL drive DATA_READY as (FIFO_COUNT != FIFO_DEPTH), using registered count only; a pop in the same cycle SHALL NOT raise READY when full.
REQ-014 SHALL keep DATA_IN stable-independent: a word not accepted SHALL NOT be lost or partially stored.
REQ-015 SHALL frame each word as: start bit 1, DATA_WIDTH data bits MSB first, optional parity bit (REQ-027), stop bit 0; line idles at 0.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP; state and DATA_OUT SHALL change only on an edge where BIT_CE=1.
REQ-017 IDLE: on BIT_CE with FIFO non-empty, pop head word into shift register, DATA_OUT<=1, go START; otherwise hold DATA_OUT=0.
REQ-018 START: on BIT_CE, DATA_OUT<=word[DATA_WIDTH-1], bit counter<=DATA_WIDTH-1, go DATA.
REQ-019 DATA: on BIT_CE, if counter=0 go PARITY (parity enabled, DATA_OUT<=parity) or STOP (DATA_OUT<=0); else DATA_OUT<=next lower bit, counter decrements.
REQ-020 PARITY: on BIT_CE, DATA_OUT<=0, go STOP.
REQ-021 STOP: on BIT_CE, if FIFO non-empty pop, DATA_OUT<=1, go START (back-to-back, no idle bit); else DATA_OUT<=0, go IDLE.
REQ-022 Pop SHALL use the registered occupancy; a word pushed in the same cycle as an IDLE/STOP BIT_CE into an empty FIFO SHALL be sent at the next BIT_CE.
REQ-023 Simultaneous push and pop SHALL leave FIFO_COUNT unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-024 BUSY SHALL be 1 when state != IDLE or FIFO_COUNT != 0.
REQ-025 BIT_CE held high every cycle SHALL yield one bit per BUS_CLK cycle.

Reset
REQ-026 While BUS_RST=1 at an edge: state<=IDLE, DATA_OUT<=0, FIFO_COUNT<=0, pointers<=0, counter<=0; DATA_READY=1, BUSY=0 the cycle after; reset mid-frame SHALL abort the frame with no further frame bits emitted.

Configuration
REQ-027 With macro TDC_TX_PARITY_EN defined, SHALL emit an even-parity bit (XOR of all data bits) after the data bits, frame length DATA_WIDTH+3; without it, PARITY state SHALL be absent and frame length SHALL be DATA_WIDTH+2.

Verification
REQ-028 Parity on, BIT_CE=1 always, push 0xA5C3 into empty FIFO -> DATA_OUT from the cycle after first pop: 1, 1010010111000011, 0, 0, then idle 0; BUSY drops after stop.
REQ-029 Parity off, push 0x0001 -> DATA_OUT 1, 0000000000000001, 0 (18 bits), then 0.
REQ-030 Push 5 words back-to-back with BIT_CE low -> first 4 accepted, DATA_READY=0 and FIFO_COUNT=4 on the 5th; word 5 accepted only after first pop.
REQ-031 BIT_CE every 4th cycle, parity on, words 0xFFFF then 0x0000 queued -> each bit held exactly 4 cycles; frames adjacent with stop 0 directly followed by start 1; parity bits 0 and 0.
REQ-032 BUS_RST asserted for 1 cycle at data bit 7 of a frame with 2 words queued -> DATA_OUT=0 next cycle, FIFO_COUNT=0, DATA_READY=1, no further frame bits until a new push.
